mc_maindec: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select. It produces the 2-bit `aluop` consumed by the downstream ALU decoder, which turns `aluop` plus `funct` into the 3-bit ALU control. It also combines `branch` with the ALU `zero` flag to form the PC enable.

---
 rtl/mc_maindec.sv | 140 ++++++++++++++
 tb/tb_mc_maindec.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_maindec.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath controls.
module mc_maindec (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       pcen,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_n;

  always_comb begin
    state_n = FETCH;
    unique case (state_q)
      FETCH:   state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = RTYPEEX;
          OP_BEQ:       state_n = BEQEX;
          OP_ADDI:      state_n = ADDIEX;
          OP_J:         state_n = JEX;
          default:      state_n = FETCH;
        endcase
      end
      MEMADR:  state_n = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_n = MEMWB;
      RTYPEEX: state_n = RTYPEWB;
      ADDIEX:  state_n = ADDIWB;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_n;
  end

  // Moore decode; unlisted and illegal encodings leave every control at 0
  always_comb begin
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = '0;
    pcsrc    = '0;
    aluop    = '0;
    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        aluop   = 2'b01;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      default: ;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Self-checking bench for mc_maindec: expected state/control words are queued
// per instruction and compared cycle by cycle against the DUT.
module tb_mc_maindec;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       memwrite, iord, irwrite, pcwrite, branch, pcen;
  logic       regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctrl;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mc_maindec dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .pcen(pcen), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .state(state)
  );

  // {memwrite,iord,irwrite,pcwrite,branch,pcen,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop}
  logic [15:0] act;
  assign act = {memwrite, iord, irwrite, pcwrite, branch, pcen, regdst, memtoreg,
                regwrite, alusrca, alusrcb, pcsrc, aluop};

  function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic z);
    logic mw, io, irw, pw, br, rd, m2r, rw, asa;
    logic [1:0] asb, ps, ao;
    {mw, io, irw, pw, br, rd, m2r, rw, asa} = '0;
    asb = '0; ps = '0; ao = '0;
    case (s)
      4'd0:  begin irw = 1; pw = 1; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  io = 1;
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin io = 1; mw = 1; end
      4'd6:  begin asa = 1; ao = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin asa = 1; br = 1; ps = 2'b01; ao = 2'b01; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {mw, io, irw, pw, br, pw | (br & z), rd, m2r, rw, asa, asb, ps, ao};
  endfunction

  task automatic push(input logic [3:0] s);
    exp_t e;
    e.st   = s;
    e.ctrl = exp_ctrl(s, zero);
    sb.push_back(e);
  endtask

  task automatic check_now(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, state=%0d", name, state);
    end else begin
      e = sb.pop_front();
      if (state !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", name, state, e.st);
      end
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl in state %0d: got %b expected %b", name, e.st, act, e.ctrl);
      end
    end
  endtask

  // Queue one instruction's state walk, then check each cycle and end back in FETCH.
  task automatic run_instr(input string name, input logic [5:0] o, input logic z,
                           input logic [3:0] seq[$]);
    op   = o;
    zero = z;
    foreach (seq[i]) push(seq[i]);
    foreach (seq[i]) begin
      check_now(name);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op    = 6'b111111;
    zero  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push(4'd0);
    check_now("reset_fetch");
    checks++;
    if ({irwrite, pcwrite, pcen, alusrcb} !== 5'b11101) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 11101", {irwrite, pcwrite, pcen, alusrcb});
    end
    @(negedge clk);
    push(4'd1);
    check_now("reset_decode");
    @(negedge clk);
  endtask

  task automatic test_lw();
    run_instr("lw", 6'b100011, 1'b0, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4});
  endtask

  task automatic test_sw_rtype();
    run_instr("sw", 6'b101011, 1'b0, '{4'd0, 4'd1, 4'd2, 4'd5});
    run_instr("rtype", 6'b000000, 1'b1, '{4'd0, 4'd1, 4'd6, 4'd7});
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'b000100, 1'b1, '{4'd0, 4'd1, 4'd8});
    run_instr("beq_not_taken", 6'b000100, 1'b0, '{4'd0, 4'd1, 4'd8});
  endtask

  task automatic test_addi_j_unknown();
    run_instr("addi", 6'b001000, 1'b0, '{4'd0, 4'd1, 4'd9, 4'd10});
    run_instr("j", 6'b000010, 1'b0, '{4'd0, 4'd1, 4'd11});
    run_instr("unknown", 6'b111111, 1'b0, '{4'd0, 4'd1});
    run_instr("unknown2", 6'b011111, 1'b1, '{4'd0, 4'd1});
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) run_instr("b2b_lw", 6'b100011, 1'b1, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4});
      else            run_instr("b2b_sw", 6'b101011, 1'b1, '{4'd0, 4'd1, 4'd2, 4'd5});
    end
  endtask

  task automatic test_reset_mid();
    logic saw_rw;
    logic [3:0] seq[$];
    saw_rw = 1'b0;
    seq = '{4'd0, 4'd1, 4'd2, 4'd3};
    op   = 6'b100011;
    zero = 1'b0;
    foreach (seq[i]) push(seq[i]);
    foreach (seq[i]) begin
      check_now("mid_reset_lw");
      saw_rw |= regwrite;
      if (i < 3) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push(4'd0);
    check_now("mid_reset_fetch");
    saw_rw |= regwrite;
    checks++;
    if (saw_rw !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_regwrite: got %b expected 0", saw_rw);
    end
    @(negedge clk);
    push(4'd1);
    check_now("mid_reset_decode");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_rtype();
    test_beq();
    test_addi_j_unknown();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
